// File: rtl/reveal_engine_pkg.sv
// reveal_engine_pkg: cell-state, board-value, FSM and neighbour-order constants shared by the reveal engine.
package reveal_engine_pkg;
  localparam logic [1:0] HIDDEN   = 2'd0;
  localparam logic [1:0] FLAGGED  = 2'd1;
  localparam logic [1:0] REVEALED = 2'd2;
  localparam logic [4:0] MINE_VAL = 5'b11111;
  localparam logic [3:0] S_WAIT_INIT  = 4'd0;
  localparam logic [3:0] S_IDLE       = 4'd1;
  localparam logic [3:0] S_FIRST_READ = 4'd2;
  localparam logic [3:0] S_FIRST_EVAL = 4'd3;
  localparam logic [3:0] S_POP        = 4'd4;
  localparam logic [3:0] S_NBR        = 4'd5;
  localparam logic [3:0] S_NBR_READ   = 4'd6;
  localparam logic [3:0] S_NBR_EVAL   = 4'd7;
  localparam logic [3:0] S_CHECK_WIN  = 4'd8;
  localparam logic [2:0] NBR_U  = 3'd0;
  localparam logic [2:0] NBR_D  = 3'd1;
  localparam logic [2:0] NBR_L  = 3'd2;
  localparam logic [2:0] NBR_R  = 3'd3;
  localparam logic [2:0] NBR_UL = 3'd4;
  localparam logic [2:0] NBR_UR = 3'd5;
  localparam logic [2:0] NBR_DL = 3'd6;
  localparam logic [2:0] NBR_DR = 3'd7;
  typedef struct packed {
    logic xm;
    logic xp;
    logic ym;
    logic yp;
  } nbr_dir_t;
  function automatic nbr_dir_t nbr_dir(input logic [2:0] k);
    nbr_dir_t d;
    d.xm = (k == NBR_L) || (k == NBR_UL) || (k == NBR_DL);
    d.xp = (k == NBR_R) || (k == NBR_UR) || (k == NBR_DR);
    d.ym = (k == NBR_U) || (k == NBR_UL) || (k == NBR_UR);
    d.yp = (k == NBR_D) || (k == NBR_DL) || (k == NBR_DR);
    return d;
  endfunction
endpackage

// File: rtl/reveal_engine_coord_stack.sv
// coord_stack: synchronous LIFO of packed {y, x} coordinates; dout shows the current top entry.
module coord_stack #(
  parameter int width = 8,
  parameter int depth = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             empty
);
  localparam int aw = $clog2(depth + 1);
  localparam int ia = $clog2(depth);
  logic [width-1:0] mem_q [depth];
  logic [aw-1:0] sp_q, sp_d;
  always_comb sp_d = push ? sp_q + aw'(1) : pop ? sp_q - aw'(1) : sp_q;
  assign empty = sp_q == '0;
  assign dout = mem_q[ia'(sp_q - aw'(1))];
  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else sp_q <= sp_d;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[ia'(sp_q)] <= din;
  end
endmodule

// File: rtl/reveal_engine.sv
// reveal_engine: player reveal/flag handling, per-cell state array and stack-based flood fill over zero cells.
module reveal_engine
  import reveal_engine_pkg::*;
#(
  parameter int x_size = 16,
  parameter int y_size = 16,
  parameter int x_coord_bits = 4,
  parameter int y_coord_bits = 4,
  parameter int init_wait = 514
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 reveal_req,
  input  logic                                 flag_req,
  input  logic [x_coord_bits-1:0]              req_x,
  input  logic [y_coord_bits-1:0]              req_y,
  input  logic [x_coord_bits+y_coord_bits-1:0] num_mines,
  input  logic [4:0]                           cell_val,
  output logic [x_coord_bits-1:0]              rd_x,
  output logic [y_coord_bits-1:0]              rd_y,
  input  logic [x_coord_bits-1:0]              query_x,
  input  logic [y_coord_bits-1:0]              query_y,
  output logic [1:0]                           query_state,
  output logic                                 busy,
  output logic [x_coord_bits+y_coord_bits:0]   revealed_count,
  output logic                                 game_lost,
  output logic                                 game_won
);
  localparam int cb = x_coord_bits + y_coord_bits;
  localparam int wb = $clog2(init_wait + 1);
  localparam logic [x_coord_bits-1:0] x_max = x_coord_bits'(x_size - 1);
  localparam logic [y_coord_bits-1:0] y_max = y_coord_bits'(y_size - 1);
  localparam logic [cb:0] n_cells = (cb + 1)'(x_size * y_size);
  logic [1:0] cell_q [2**cb];
  logic [3:0] state_q, state_d;
  logic [wb-1:0] wait_q, wait_d;
  logic rw_q, rw_d;
  logic [2:0] k_q, k_d;
  logic [x_coord_bits-1:0] rx_q, rx_d, cx_q, cx_d, nx;
  logic [y_coord_bits-1:0] ry_q, ry_d, cy_q, cy_d, ny;
  logic [cb:0] cnt_q, cnt_d;
  logic lost_q, lost_d, won_q, won_d;
  logic [1:0] qs_q, qs_d, req_cell, cw_val;
  logic cw_en, push, pop, empty, nbr_ok;
  logic [cb-1:0] cw_idx, top;
  nbr_dir_t dir;
  coord_stack #(.width(cb), .depth(x_size * y_size)) u_stack (
    .clk  (clk),
    .rst  (reset),
    .push (push),
    .pop  (pop),
    .din  ({ry_q, rx_q}),
    .dout (top),
    .empty(empty)
  );
  always_comb begin
    dir = nbr_dir(k_q);
    // Neighbour address is only consumed after the edge checks below, so adder wrap is harmless.
    nx = cx_q + {{(x_coord_bits-1){dir.xm}}, dir.xm | dir.xp};
    ny = cy_q + {{(y_coord_bits-1){dir.ym}}, dir.ym | dir.yp};
    nbr_ok = !(dir.xm && cx_q == '0) && !(dir.xp && cx_q == x_max) &&
             !(dir.ym && cy_q == '0) && !(dir.yp && cy_q == y_max) &&
             cell_q[{ny, nx}] == HIDDEN;
    req_cell = cell_q[{req_y, req_x}];
    qs_d = cell_q[{query_y, query_x}];
    state_d = state_q;
    wait_d = wait_q;
    rw_d = rw_q;
    k_d = k_q;
    rx_d = rx_q;
    ry_d = ry_q;
    cx_d = cx_q;
    cy_d = cy_q;
    cnt_d = cnt_q;
    lost_d = lost_q;
    won_d = won_q;
    cw_en = 1'b0;
    cw_idx = {ry_q, rx_q};
    cw_val = REVEALED;
    push = 1'b0;
    pop = 1'b0;
    case (state_q)
      S_WAIT_INIT: begin
        wait_d = wait_q + wb'(1);
        state_d = wait_q == wb'(init_wait - 1) ? S_IDLE : S_WAIT_INIT;
      end
      S_IDLE: begin
        if (!lost_q && !won_q && reveal_req && req_cell == HIDDEN) begin
          rx_d = req_x;
          ry_d = req_y;
          rw_d = 1'b0;
          state_d = S_FIRST_READ;
        end else if (!lost_q && !won_q && !reveal_req && flag_req && req_cell != REVEALED) begin
          cw_en = 1'b1;
          cw_idx = {req_y, req_x};
          cw_val = req_cell == HIDDEN ? FLAGGED : HIDDEN;
        end
      end
      S_FIRST_READ, S_NBR_READ: begin
        rw_d = 1'b1;
        state_d = !rw_q ? state_q : state_q == S_FIRST_READ ? S_FIRST_EVAL : S_NBR_EVAL;
      end
      S_FIRST_EVAL: begin
        cw_en = 1'b1;
        lost_d = cell_val == MINE_VAL;
        cnt_d = cell_val == MINE_VAL ? cnt_q : cnt_q + (cb + 1)'(1);
        push = cell_val == 5'd0;
        state_d = cell_val == MINE_VAL ? S_IDLE : cell_val == 5'd0 ? S_POP : S_CHECK_WIN;
      end
      S_POP: begin
        pop = !empty;
        {cy_d, cx_d} = empty ? {cy_q, cx_q} : top;
        k_d = 3'd0;
        state_d = empty ? S_CHECK_WIN : S_NBR;
      end
      S_NBR: begin
        rx_d = nbr_ok ? nx : rx_q;
        ry_d = nbr_ok ? ny : ry_q;
        rw_d = 1'b0;
        k_d = nbr_ok ? k_q : k_q + 3'd1;
        state_d = nbr_ok ? S_NBR_READ : k_q == NBR_DR ? S_POP : S_NBR;
      end
      S_NBR_EVAL: begin
        cw_en = 1'b1;
        cnt_d = cnt_q + (cb + 1)'(1);
        push = cell_val == 5'd0;
        k_d = k_q + 3'd1;
        state_d = k_q == NBR_DR ? S_POP : S_NBR;
      end
      S_CHECK_WIN: begin
        won_d = cnt_q == n_cells - {1'b0, num_mines};
        state_d = S_IDLE;
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_INIT;
      wait_q <= '0;
      rw_q <= 1'b0;
      k_q <= 3'd0;
      rx_q <= '0;
      ry_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      cnt_q <= '0;
      lost_q <= 1'b0;
      won_q <= 1'b0;
      qs_q <= HIDDEN;
      for (int i = 0; i < 2**cb; i++) cell_q[i] <= HIDDEN;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      rw_q <= rw_d;
      k_q <= k_d;
      rx_q <= rx_d;
      ry_q <= ry_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      cnt_q <= cnt_d;
      lost_q <= lost_d;
      won_q <= won_d;
      qs_q <= qs_d;
      if (cw_en) cell_q[cw_idx] <= cw_val;
    end
  end
  assign rd_x = rx_q;
  assign rd_y = ry_q;
  assign query_state = qs_q;
  assign busy = state_q != S_IDLE;
  assign revealed_count = cnt_q;
  assign game_lost = lost_q;
  assign game_won = won_q;
endmodule

// File: tb/tb_reveal_engine.sv
// tb_reveal_engine: board model with 2-cycle read port, queue-based flood reference model and per-cycle compare.
module tb_reveal_engine;
  logic clk = 0, reset = 1, reveal_req = 0, flag_req = 0;
  logic [3:0] req_x = 0, req_y = 0, query_x = 0, query_y = 0, rd_x, rd_y;
  logic [7:0] num_mines = 0;
  logic [4:0] cell_val = 0, p1 = 0;
  logic [1:0] query_state;
  logic busy, game_lost, game_won;
  logic [8:0] revealed_count;
  logic [4:0] board [16][16];
  bit mine [16][16];
  int m_cell [16][16];
  int m_cnt = 0, checks = 0, errors = 0, cyc = 0, qpx = 0, qpy = 0, c0;
  bit m_lost = 0, m_won = 0, chk_en = 0, chk_prev = 0, q_fixed = 0;
  logic [3:0] qfx = 0, qfy = 0;

  reveal_engine dut (
    .clk(clk), .reset(reset), .reveal_req(reveal_req), .flag_req(flag_req),
    .req_x(req_x), .req_y(req_y), .num_mines(num_mines), .cell_val(cell_val),
    .rd_x(rd_x), .rd_y(rd_y), .query_x(query_x), .query_y(query_y),
    .query_state(query_state), .busy(busy), .revealed_count(revealed_count),
    .game_lost(game_lost), .game_won(game_won)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1 <= board[rd_y][rd_x];
    cell_val <= p1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !busy) begin
      chk("count", revealed_count, m_cnt);
      chk("lost", game_lost, m_lost);
      chk("won", game_won, m_won);
      if (chk_prev) chk("query", query_state, m_cell[qpy][qpx]);
    end
    chk_prev = chk_en && !busy;
    query_x = q_fixed ? qfx : 4'($urandom_range(15));
    query_y = q_fixed ? qfy : 4'($urandom_range(15));
    qpx = query_x;
    qpy = query_y;
  end

  task automatic m_clear();
    foreach (m_cell[y, x]) m_cell[y][x] = 0;
    m_cnt = 0;
    m_lost = 0;
    m_won = 0;
  endtask

  task automatic m_reveal(input int x, input int y);
    int qx[$], qy[$];
    int cx, cy, nx, ny;
    if (m_lost || m_won || m_cell[y][x] != 0) return;
    m_cell[y][x] = 2;
    if (board[y][x] == 5'h1f) begin
      m_lost = 1;
      return;
    end
    m_cnt++;
    if (board[y][x] == 0) begin qx.push_back(x); qy.push_back(y); end
    while (qx.size() > 0) begin
      cx = qx.pop_front();
      cy = qy.pop_front();
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          nx = cx + dx;
          ny = cy + dy;
          if ((dx != 0 || dy != 0) && nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && m_cell[ny][nx] == 0) begin
            m_cell[ny][nx] = 2;
            m_cnt++;
            if (board[ny][nx] == 0) begin qx.push_back(nx); qy.push_back(ny); end
          end
        end
    end
    m_won = m_cnt == 256 - int'(num_mines);
  endtask

  task automatic m_flag(input int x, input int y);
    if (!m_lost && !m_won && m_cell[y][x] != 2) m_cell[y][x] = 1 - m_cell[y][x];
  endtask

  task automatic set_board();
    int n, m;
    m = 0;
    foreach (board[y, x]) begin
      n = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          if (x + dx >= 0 && x + dx < 16 && y + dy >= 0 && y + dy < 16 && mine[y + dy][x + dx]) n++;
      board[y][x] = mine[y][x] ? 5'h1f : 5'(n);
      if (mine[y][x]) m++;
    end
    num_mines = 8'(m);
  endtask

  task automatic clear_mines();
    foreach (mine[y, x]) mine[y][x] = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin @(posedge clk); #1; n++; end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic settle();
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    m_clear();
    wait_idle();
    settle();
  endtask

  task automatic request(input bit r, input bit f, input int x, input int y);
    chk_en = 0;
    @(posedge clk); #1;
    reveal_req = r; flag_req = f; req_x = 4'(x); req_y = 4'(y);
    @(posedge clk); #1;
    reveal_req = 0; flag_req = 0;
    wait_idle();
    if (r) m_reveal(x, y);
    else if (f) m_flag(x, y);
    settle();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n, t;
    clear_mines();
    mine[3][3] = 1;
    set_board();
    m_clear();
    @(posedge clk); #1 reset = 0;
    c0 = cyc;
    chk("reset_busy", busy, 1);
    chk("reset_count", revealed_count, 0);
    chk("reset_lost", game_lost, 0);
    chk("reset_won", game_won, 0);
    chk("reset_rd", {rd_y, rd_x}, 0);
    chk("reset_query", query_state, 0);
    repeat (9) @(posedge clk);
    #1 reveal_req = 1;
    @(posedge clk); #1 reveal_req = 0;
    wait_idle();
    chk("init_cycles", cyc - c0, 514);
    chk("init_count", revealed_count, 0);
    settle();
    // Mine hit: loss must show three edges after the request edge.
    chk_en = 0;
    @(posedge clk); #1 reveal_req = 1; req_x = 3; req_y = 3;
    @(posedge clk); #1 reveal_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lost_early", game_lost, 0);
    @(posedge clk); #1;
    chk("lost_at_3", game_lost, 1);
    wait_idle();
    m_reveal(3, 3);
    settle();
    request(1, 0, 0, 0);
    chk("lost_count", revealed_count, 0);
    chk("lost_sticky", game_lost, 1);
    do_reset();
    q_fixed = 1; qfx = 5; qfy = 5;
    request(0, 1, 5, 5);
    chk("flag_set", query_state, 1);
    request(1, 0, 5, 5);
    chk("flagged_no_read", {rd_y, rd_x}, 0);
    chk("flagged_stays", query_state, 1);
    request(0, 1, 5, 5);
    chk("unflag", query_state, 0);
    request(1, 1, 5, 5);
    chk("reveal_wins", query_state, 2);
    request(0, 1, 5, 5);
    chk("flag_revealed_ignored", query_state, 2);
    q_fixed = 0;
    clear_mines();
    set_board();
    do_reset();
    request(1, 0, 0, 0);
    chk("zero_count", revealed_count, 256);
    chk("zero_won", game_won, 1);
    mine[15][15] = 1;
    set_board();
    do_reset();
    request(1, 0, 0, 0);
    chk("corner_count", revealed_count, 255);
    chk("corner_won", game_won, 1);
    do_reset();
    request(0, 1, 14, 14);
    request(1, 0, 0, 0);
    chk("preflag_count", revealed_count, 254);
    chk("preflag_won", game_won, 0);
    // Reset in the middle of a flood.
    clear_mines();
    set_board();
    do_reset();
    q_fixed = 1; qfx = 1; qfy = 0;
    chk_en = 0;
    @(posedge clk); #1 reveal_req = 1; req_x = 0; req_y = 0;
    @(posedge clk); #1 reveal_req = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_query", query_state, 2);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    chk("abort_busy", busy, 1);
    chk("abort_count", revealed_count, 0);
    chk("abort_query", query_state, 0);
    chk("abort_rd", {rd_y, rd_x}, 0);
    @(posedge clk); #1;
    chk("abort_cell", query_state, 0);
    chk("abort_lost_won", {game_lost, game_won}, 0);
    m_clear();
    wait_idle();
    settle();
    q_fixed = 0;
    request(1, 0, 0, 0);
    chk("after_abort_count", revealed_count, 256);
    repeat (4) begin
      clear_mines();
      n = 1 + $urandom_range(29);
      while (n > 0) begin
        t = $urandom_range(255);
        if (!mine[t / 16][t % 16]) begin mine[t / 16][t % 16] = 1; n--; end
      end
      set_board();
      do_reset();
      repeat (25) begin
        t = $urandom_range(9);
        request(t < 6 || t == 9, t >= 6, $urandom_range(15), $urandom_range(15));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reveal_engine.md
Name: reveal_engine

Overview:
- Game-logic stage directly downstream of the board generator.
- Accepts player reveal/flag requests and reads cell values from the board through its registered read port (x_coord/y_coord -> cell_val).
- Keeps a per-cell hidden/flagged/revealed state array and runs an iterative flood-fill over zero cells using an explicit stack.
- Reports loss (mine revealed) and win (all safe cells revealed) to the display/top level.

Parameters:
x_size, 16, board width in cells
y_size, 16, board height in cells
x_coord_bits, 4, width of x coordinates
y_coord_bits, 4, width of y coordinates
init_wait, 514, cycles after reset before requests are accepted (board init = 2*x_size*y_size + 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
reveal_req  in  1  one-cycle pulse: reveal cell (req_x, req_y)
flag_req  in  1  one-cycle pulse: toggle flag on (req_x, req_y)
req_x  in  x_coord_bits  request column
req_y  in  y_coord_bits  request row
num_mines  in  x_coord_bits+y_coord_bits  mine count from board
cell_val  in  5  board read data; bit 4 set = mine (5'b11111)
rd_x  out  x_coord_bits  registered board read column
rd_y  out  y_coord_bits  registered board read row
query_x  in  x_coord_bits  display query column
query_y  in  y_coord_bits  display query row
query_state  out  2  state of query cell, 1-cycle latency: 0 hidden, 1 flagged, 2 revealed
busy  out  1  high whenever FSM is not in IDLE (WAIT_INIT included)
revealed_count  out  x_coord_bits+y_coord_bits+1  number of revealed cells
game_lost  out  1  sticky until reset
game_won  out  1  sticky until reset

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. Every flop is updated only on the rising edge of clk.
- Reset response (sampled at a clk edge):
  - all cells hidden; stack pointer 0
  - rd_x/rd_y = 0, query_state = 0, revealed_count = 0
  - game_lost = game_won = 0, busy = 1
  - FSM enters WAIT_INIT; wait counter cleared
- Reset asserted mid-flood aborts the flood immediately, with the same result as above.
- Board read latency: cell_val is valid exactly 2 clocks after rd_x/rd_y update. The READ state therefore waits 2 cycles before sampling.
- FSM states:
  - WAIT_INIT: count init_wait cycles -> IDLE.
  - IDLE:
    - if game_lost or game_won, ignore all requests.
    - reveal_req has priority over a simultaneous flag_req.
    - flag_req on a hidden cell -> flagged; on a flagged cell -> hidden. Takes 1 cycle, stays in IDLE. Ignored on a revealed cell.
    - reveal_req on a hidden cell: latch the coordinate, drive rd_x/rd_y -> FIRST_READ. Ignored on a flagged or revealed cell.
  - FIRST_READ (2 cycles) -> FIRST_EVAL.
  - FIRST_EVAL:
    - mine: set game_lost, cell -> revealed, -> IDLE.
    - otherwise: cell -> revealed, revealed_count++.
    - value 0: push coordinate -> POP. Nonzero: -> CHECK_WIN.
  - POP:
    - stack empty -> CHECK_WIN.
    - otherwise pop into centre register, k = 0 -> NBR.
  - NBR: neighbour k in order U, D, L, R, UL, UR, DL, DR.
    - out of bounds, or not hidden (flagged cells are never auto-revealed): skip in 1 cycle.
    - otherwise drive rd_x/rd_y -> NBR_READ (2 cycles) -> NBR_EVAL.
  - NBR_EVAL: cell -> revealed, revealed_count++, push if value is 0. Then k++; after k = 7 -> POP.
  - CHECK_WIN: if revealed_count == x_size*y_size - num_mines, set game_won. -> IDLE.
- Stack sizing: a cell is marked revealed when evaluated, so each cell is pushed at most once. Stack depth x_size*y_size therefore never overflows; no overflow logic is required.
- Bounds checks compare coordinates before the +/-1 arithmetic; wrap-around of coordinate adders is never used.
- Requests arriving while busy are dropped. There is no queueing.
- query_state is a registered lookup, independent of the FSM, and is valid every cycle including while busy.

Decomposition:
- Shared package holds:
  - cell-state encodings HIDDEN = 2'd0, FLAGGED = 2'd1, REVEALED = 2'd2
  - MINE_VAL = 5'b11111
  - FSM state encodings
  - neighbour-order constants
- One natural sub-module: coord_stack, a synchronous LIFO of {y, x} with push, pop, empty and depth parameter. The state array and FSM stay in reveal_engine.

Test Plan:
- Reset, then reveal_req at cycle 10 -> ignored; busy high for 514 cycles, then low; revealed_count = 0.
- Board with a mine at (3,3); reveal (3,3) -> game_lost = 1 after 3 cycles; further reveal_req ignored; count stays 0.
- flag (5,5), then reveal (5,5) -> no read issued, state stays 1. Flag (5,5) again -> state 0. A simultaneous reveal_req + flag_req on a hidden cell -> reveal wins.
- All-zero 16x16 board with num_mines = 0 and board values 0; reveal (0,0) -> flood reveals all 256 cells; revealed_count = 256; game_won = 1; stack never exceeds 256.
- A single mine at (15,15) with neighbours = 1, others 0; reveal (0,0) -> 255 revealed, game_won = 1. Pre-flagging (14,14) -> 254 revealed, won stays 0.
- Assert reset mid-flood -> next cycle all query_state = 0, count = 0, busy = 1, FSM in WAIT_INIT.
